// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the mem_arbiter and the memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        if_stall;
  logic        d_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, if_stall, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, if_stall, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory port.
// Define ARB_ROUND_ROBIN_EN for alternating grants; otherwise data always beats fetch.
module mem_arbiter #(
  parameter int LAT = 4
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        grant_i, grant_d, done, prio_d;
  logic        mem_en_reg, mem_wr_reg;
  logic [15:0] mem_addr_reg, mem_wdata_reg;
  logic [15:0] if_rdata_reg, d_rdata_reg;
  logic        if_valid_reg, d_valid_reg;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers whether the most recent grant went to the data side.
  logic last_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_reg <= 1'b0;
    end else if (grant_d || grant_i) begin
      last_d_reg <= grant_d;
    end
  end

  assign prio_d = ~last_d_reg;
`else
  assign prio_d = 1'b1;
`endif

  assign done = (state_reg != IDLE) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.d_req && (prio_d || !bus.if_req)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (bus.if_req) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= 4'd0;
      mem_en_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= 16'h0000;
      mem_wdata_reg <= 16'h0000;
      if_rdata_reg  <= 16'h0000;
      d_rdata_reg   <= 16'h0000;
      if_valid_reg  <= 1'b0;
      d_valid_reg   <= 1'b0;
    end else begin
      mem_en_reg   <= grant_i || grant_d;
      if_valid_reg <= done && (state_reg == BUSY_I);
      d_valid_reg  <= done && (state_reg == BUSY_D);

      // Address/data are frozen at grant so the other side cannot disturb them.
      if (grant_d) begin
        cnt_reg       <= 4'd0;
        mem_wr_reg    <= bus.d_wr;
        mem_addr_reg  <= bus.d_addr;
        mem_wdata_reg <= bus.d_wdata;
      end else if (grant_i) begin
        cnt_reg       <= 4'd0;
        mem_wr_reg    <= 1'b0;
        mem_addr_reg  <= bus.if_addr;
        mem_wdata_reg <= 16'h0000;
      end else if (state_reg != IDLE) begin
        cnt_reg <= cnt_reg + 4'd1;
      end

      if (done && (state_reg == BUSY_I)) begin
        if_rdata_reg <= bus.mem_rdata;
      end
      if (done && (state_reg == BUSY_D) && !mem_wr_reg) begin
        d_rdata_reg <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_wr    = mem_wr_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.if_valid  = if_valid_reg;
  assign bus.d_valid   = d_valid_reg;
  assign bus.if_stall  = bus.if_req & ~if_valid_reg;
  assign bus.d_stall   = bus.d_req & ~d_valid_reg;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 4, memory read latency in cycles, legal range 1..15.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 if_req  input  1  fetch request; held high until if_valid.
REQ-006 if_addr  input  16  fetch word address.
REQ-007 if_rdata  output  16  fetched instruction, registered.
REQ-008 if_valid  output  1  one-cycle pulse; if_rdata is valid in that cycle.
REQ-009 d_req  input  1  data request; held high until d_valid.
REQ-010 d_wr  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  16  data word address.
REQ-012 d_wdata  input  16  store data.
REQ-013 d_rdata  output  16  load data, registered.
REQ-014 d_valid  output  1  one-cycle completion pulse for a load or a store.
REQ-015 if_stall  output  1  combinational: if_req & ~if_valid.
REQ-016 d_stall  output  1  combinational: d_req & ~d_valid.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_wr  output  1  memory write enable.
REQ-019 mem_addr  output  16  memory address.
REQ-020 mem_wdata  output  16  memory write data.
REQ-021 mem_rdata  input  16  memory read data; valid LAT cycles after mem_en.

Function
REQ-022 FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE -> BUSY_D on d_req.
- IDLE -> BUSY_I on if_req with no d_req.
- Otherwise the FSM stays in IDLE.
REQ-023 On entry to BUSY_x:
- latch the winning requester's address, wr (0 for fetch) and wdata into mem_addr, mem_wr, mem_wdata;
- clear the 4-bit counter.
REQ-024 mem_en is high only in the first BUSY cycle; mem_addr, mem_wr and mem_wdata stay stable for the whole BUSY period.
REQ-025 The counter increments every BUSY cycle. When the counter equals LAT-1 at a rising edge:
- capture mem_rdata into x_rdata (loads and fetches only);
- pulse x_valid for the next cycle;
- move to IDLE.
REQ-026 Latency: a request sampled at edge T yields x_valid high in cycle T+LAT+1. Maximum throughput is one access per LAT+1 cycles.
REQ-027 In the IDLE cycle that carries x_valid, a pending request is sampled and granted normally. Back-to-back accesses have no bubble beyond that cycle.
REQ-028 A store leaves d_rdata unchanged and still pulses d_valid.
REQ-029 A requester that drops req during BUSY does not abort the access; the access completes and x_valid still pulses.
REQ-030 Requests and address changes from the non-granted side during BUSY are ignored until IDLE.
REQ-031 if_valid and d_valid are never high in the same cycle.

Reset
REQ-032 rst_n low forces, immediately:
- state = IDLE, counter = 0;
- if_rdata = d_rdata = 0, if_valid = d_valid = 0;
- mem_en = mem_wr = 0, mem_addr = mem_wdata = 0;
- round-robin pointer = data-side priority.
REQ-033 Reset during BUSY abandons the access; no valid pulse follows after reset release.
REQ-034 The first grant is evaluated at the first rising edge with rst_n high.

Configuration
REQ-035 Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant register is updated on every grant. When if_req and d_req are both high in IDLE, the side not granted last time wins.
- Undefined: fixed data-over-fetch priority; no last-grant register.

Verification (LAT=4)
REQ-036 Fetch if_addr=0x0010, mem returns 0xA5A5 -> mem_en pulses once with mem_addr=0x0010, mem_wr=0; if_valid pulses 5 cycles after the request edge with if_rdata=0xA5A5.
REQ-037 Store d_addr=0x0200, d_wdata=0x1234 -> mem_en=1, mem_wr=1, mem_wdata=0x1234; d_valid pulses at cycle 5; d_rdata unchanged.
REQ-038 if_req and d_req both held high, macro undefined -> D is granted first, then I; valids at cycles 5 and 10; the I address is not issued before D completes.
REQ-039 As REQ-038 with ARB_ROUND_ROBIN_EN defined and both requests held high for 4 accesses -> grants alternate D, I, D, I.
REQ-040 rst_n low at cycle 2 of a BUSY_I access, released 3 cycles later -> all outputs are 0 immediately; no if_valid pulse appears before a new request.
REQ-041 Load with d_req dropped after 1 cycle, mem returns 0xBEEF -> d_valid still pulses at cycle 5 with d_rdata=0xBEEF.
